ti_stop_responder: RTL and testbench



---
 rtl/ti_pkg.sv | 22 ++
 rtl/ti_outstanding_counter.sv | 48 ++++
 rtl/ti_stop_responder.sv | 115 +++++++++++
 tb/tb_ti_stop_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ti_pkg.sv
// Shared definitions for the stop_req/stop_ack freeze handshake used by the
// interruption controller and the per-task stop responders.
package ti_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    STOPPED = 2'd2
  } ti_state_e;

  localparam int TI_CNT_W             = 5;
  localparam int TI_MAX_OUTSTANDING   = 16;
  localparam int TI_TIMEOUT_CYCLES    = 1024;
  localparam logic TI_STOP_ASSERTED   = 1'b1;
  localparam logic TI_TASK_CLK_ON     = 1'b1;

  // Timer must hold TIMEOUT_CYCLES itself (saturation value); at least 1 bit.
  function automatic int ti_timer_w(input int timeout_cycles);
    return $clog2(timeout_cycles + 2);
  endfunction

endpackage

// File: rtl/ti_outstanding_counter.sv
// In-flight request counter: +1 per accepted request, -1 per response,
// holds at zero on a stray response and reports it as an underflow pulse.
module ti_outstanding_counter
  import ti_pkg::*;
#(
  parameter int MAX_OUTSTANDING = TI_MAX_OUTSTANDING,
  parameter int CNT_W           = TI_CNT_W
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             at_max,
  output logic             is_zero,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign count     = count_q;
  assign at_max    = (count_q >= MAX_CNT);
  assign is_zero   = (count_q == '0);
  assign underflow = dec & is_zero;

  // NOTE: combinational blocks assign every output a default first so no path leaves a latch.
  always_comb begin
    count_d = count_q;
    if (inc && !dec && !at_max) begin
      count_d = count_q + CNT_W'(1);
    end else if (dec && !inc && !is_zero) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments; the reset is synchronous, so it sits inside the clocked branch.
  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ti_stop_responder.sv
// Task-side end of the stop handshake: blocks new requests on stop_req,
// drains in-flight traffic, then acks and gates the task clock.
module ti_stop_responder
  import ti_pkg::*;
#(
  parameter int MAX_OUTSTANDING = TI_MAX_OUTSTANDING,
  parameter int CNT_W           = TI_CNT_W,
  parameter int TIMEOUT_CYCLES  = TI_TIMEOUT_CYCLES
) (
  input  logic             sys_clk,
  input  logic             sys_reset,
  input  logic             stop_req,
  output logic             stop_ack,
  output logic             task_clk_en,
  input  logic             s_req_valid,
  output logic             s_req_ready,
  output logic             m_req_valid,
  input  logic             m_req_ready,
  input  logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [CNT_W-1:0] outstanding,
  output logic             drain_timeout,
  output logic             protocol_err
);

  localparam int              TMR_W      = ti_timer_w(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_SAT   = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic            TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  ti_state_e        state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             drain_timeout_q, drain_timeout_d;
  logic             protocol_err_q, protocol_err_d;

  logic             req_fire, rsp_fire;
  logic             at_max, is_zero, underflow, drain_done;
  logic [CNT_W-1:0] count;

  assign req_fire = m_req_valid & m_req_ready;
  assign rsp_fire = rsp_valid & rsp_ready;

  ti_outstanding_counter #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_counter (
    .clk       (sys_clk),
    .clear     (sys_reset),
    .inc       (req_fire),
    .dec       (rsp_fire),
    .count     (count),
    .at_max    (at_max),
    .is_zero   (is_zero),
    .underflow (underflow)
  );

  // No requests are issued in DRAIN, so the count after this edge is zero
  // when it already is, or when the last outstanding response fires now.
  assign drain_done = is_zero | ((count == CNT_W'(1)) & rsp_fire);

  assign outstanding   = count;
  assign drain_timeout = drain_timeout_q;
  assign protocol_err  = protocol_err_q;

  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    drain_timeout_d = drain_timeout_q;
    protocol_err_d  = protocol_err_q | underflow;
    m_req_valid     = 1'b0;
    s_req_ready     = 1'b0;
    stop_ack        = ~TI_STOP_ASSERTED;
    task_clk_en     = TI_TASK_CLK_ON;

    case (state_q)
      RUN: begin
        m_req_valid = s_req_valid & ~at_max;
        s_req_ready = m_req_ready & ~at_max;
        timer_d     = '0;
        if (stop_req == TI_STOP_ASSERTED) state_d = DRAIN;
      end
      DRAIN: begin
        if (timer_q != TMR_SAT) timer_d = timer_q + TMR_W'(1);
        if (TIMEOUT_EN && (timer_q == TMR_LAST)) drain_timeout_d = 1'b1;
        // A released stop_req wins over a completing drain: no ack is issued.
        if (stop_req != TI_STOP_ASSERTED) begin
          state_d = RUN;
        end else if (drain_done) begin
          state_d = STOPPED;
        end
      end
      STOPPED: begin
        stop_ack    = TI_STOP_ASSERTED;
        task_clk_en = ~TI_TASK_CLK_ON;
        if (stop_req != TI_STOP_ASSERTED) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state_q         <= RUN;
      timer_q         <= '0;
      drain_timeout_q <= 1'b0;
      protocol_err_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      drain_timeout_q <= drain_timeout_d;
      protocol_err_q  <= protocol_err_d;
    end
  end

endmodule

// File: tb/tb_ti_stop_responder.sv
// Self-checking bench for ti_stop_responder: vector table with a scoreboard
// of post-edge expectations, plus hand-written reset sequences.
module tb_ti_stop_responder;

  logic       sys_clk;
  logic       sys_reset;
  logic       stop_req;
  logic       stop_ack;
  logic       task_clk_en;
  logic       s_req_valid;
  logic       s_req_ready;
  logic       m_req_valid;
  logic       m_req_ready;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [4:0] outstanding;
  logic       drain_timeout;
  logic       protocol_err;

  ti_stop_responder #(
    .MAX_OUTSTANDING (16),
    .CNT_W           (5),
    .TIMEOUT_CYCLES  (8)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_reset     (sys_reset),
    .stop_req      (stop_req),
    .stop_ack      (stop_ack),
    .task_clk_en   (task_clk_en),
    .s_req_valid   (s_req_valid),
    .s_req_ready   (s_req_ready),
    .m_req_valid   (m_req_valid),
    .m_req_ready   (m_req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .outstanding   (outstanding),
    .drain_timeout (drain_timeout),
    .protocol_err  (protocol_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Inputs applied for one cycle; comb expectations hold during that cycle,
  // registered expectations hold just after the following rising edge.
  typedef struct {
    string      name;
    logic       stop, sv, mr, rsp;
    logic       e_mvalid, e_sready;
    logic       e_ack, e_clk_en;
    logic [4:0] e_out;
    logic       e_perr, e_tmo;
  } vec_t;

  typedef struct {
    string      name;
    logic       ack, clk_en;
    logic [4:0] out;
    logic       perr, tmo;
  } reg_exp_t;

  vec_t     tbl[$];
  reg_exp_t exp_q[$];
  int       n_checks = 0;
  int       n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input string n, input logic st, input logic sv, input logic mr,
                              input logic rsp, input logic emv, input logic esr, input logic eack,
                              input logic eclk, input logic [4:0] eout, input logic eperr,
                              input logic etmo);
    vec_t v;
    v.name = n; v.stop = st; v.sv = sv; v.mr = mr; v.rsp = rsp;
    v.e_mvalid = emv; v.e_sready = esr; v.e_ack = eack; v.e_clk_en = eclk;
    v.e_out = eout; v.e_perr = eperr; v.e_tmo = etmo;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    reg_exp_t e;
    @(negedge sys_clk);
    stop_req    = v.stop;
    s_req_valid = v.sv;
    m_req_ready = v.mr;
    rsp_valid   = v.rsp;
    #1;
    check({v.name, "/m_req_valid"}, m_req_valid, v.e_mvalid);
    check({v.name, "/s_req_ready"}, s_req_ready, v.e_sready);
    exp_q.push_back('{name: v.name, ack: v.e_ack, clk_en: v.e_clk_en, out: v.e_out,
                      perr: v.e_perr, tmo: v.e_tmo});
    @(posedge sys_clk);
    #1;
    e = exp_q.pop_front();
    check({e.name, "/stop_ack"},      stop_ack,      e.ack);
    check({e.name, "/task_clk_en"},   task_clk_en,   e.clk_en);
    check({e.name, "/outstanding"},   outstanding,   e.out);
    check({e.name, "/protocol_err"},  protocol_err,  e.perr);
    check({e.name, "/drain_timeout"}, drain_timeout, e.tmo);
  endtask

  task automatic reset_and_check(input string name);
    @(negedge sys_clk);
    sys_reset = 1'b1;
    @(posedge sys_clk);
    #1;
    check({name, "/stop_ack"},      stop_ack,      1'b0);
    check({name, "/task_clk_en"},   task_clk_en,   1'b1);
    check({name, "/outstanding"},   outstanding,   5'd0);
    check({name, "/protocol_err"},  protocol_err,  1'b0);
    check({name, "/drain_timeout"}, drain_timeout, 1'b0);
    @(negedge sys_clk);
    sys_reset   = 1'b0;
    stop_req    = 1'b0;
    s_req_valid = 1'b0;
    rsp_valid   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    sys_reset = 1'b1; stop_req = 1'b0; s_req_valid = 1'b0;
    m_req_ready = 1'b0; rsp_valid = 1'b0; rsp_ready = 1'b1;

    // Idle stop: outstanding 0, ack two edges after stop_req is sampled.
    tbl.push_back(mk("idle_run",      0,0,1,0, 0,1, 0,1, 5'd0, 0,0));
    tbl.push_back(mk("idle_stopreq",  1,0,1,0, 0,1, 0,1, 5'd0, 0,0));
    tbl.push_back(mk("idle_drain",    1,1,1,0, 0,0, 1,0, 5'd0, 0,0));
    tbl.push_back(mk("idle_stopped",  1,1,1,0, 0,0, 1,0, 5'd0, 0,0));
    tbl.push_back(mk("idle_release",  0,1,1,0, 0,0, 0,1, 5'd0, 0,0));
    // Drain with three in flight; ack at the edge of the third response.
    tbl.push_back(mk("d3_issue1",     0,1,1,0, 1,1, 0,1, 5'd1, 0,0));
    tbl.push_back(mk("d3_issue2",     0,1,1,0, 1,1, 0,1, 5'd2, 0,0));
    tbl.push_back(mk("d3_issue3",     0,1,1,0, 1,1, 0,1, 5'd3, 0,0));
    tbl.push_back(mk("d3_stopreq",    1,0,1,0, 0,1, 0,1, 5'd3, 0,0));
    tbl.push_back(mk("d3_wait1",      1,1,1,0, 0,0, 0,1, 5'd3, 0,0));
    tbl.push_back(mk("d3_rsp1",       1,1,1,1, 0,0, 0,1, 5'd2, 0,0));
    tbl.push_back(mk("d3_wait2",      1,1,1,0, 0,0, 0,1, 5'd2, 0,0));
    tbl.push_back(mk("d3_rsp2",       1,1,1,1, 0,0, 0,1, 5'd1, 0,0));
    tbl.push_back(mk("d3_wait3",      1,1,1,0, 0,0, 0,1, 5'd1, 0,0));
    tbl.push_back(mk("d3_rsp3",       1,1,1,1, 0,0, 1,0, 5'd0, 0,0));
    tbl.push_back(mk("d3_release",    0,0,1,0, 0,0, 0,1, 5'd0, 0,0));
    // Limit: exactly 16 requests accepted, then one per returned response.
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk($sformatf("lim_fill%0d", i), 0,1,1,0, 1,1, 0,1, 5'(i + 1), 0,0));
    tbl.push_back(mk("lim_full",      0,1,1,0, 0,0, 0,1, 5'd16, 0,0));
    tbl.push_back(mk("lim_rsp",       0,1,1,1, 0,0, 0,1, 5'd15, 0,0));
    tbl.push_back(mk("lim_refill",    0,1,1,0, 1,1, 0,1, 5'd16, 0,0));
    tbl.push_back(mk("lim_full2",     0,1,1,0, 0,0, 0,1, 5'd16, 0,0));
    for (int i = 0; i < 11; i++)
      tbl.push_back(mk($sformatf("lim_down%0d", i), 0,0,1,1, 0,(i != 0), 0,1, 5'(15 - i), 0,0));
    // Simultaneous request and response at 5 leaves the count unchanged.
    tbl.push_back(mk("simul_at5",     0,1,1,1, 1,1, 0,1, 5'd5, 0,0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk($sformatf("simul_down%0d", i), 0,0,1,1, 0,1, 0,1, 5'(4 - i), 0,0));
    // Abort: a 3-cycle stop pulse with 2 outstanding never acks.
    tbl.push_back(mk("ab_issue1",     0,1,1,0, 1,1, 0,1, 5'd1, 0,0));
    tbl.push_back(mk("ab_issue2",     0,1,1,0, 1,1, 0,1, 5'd2, 0,0));
    tbl.push_back(mk("ab_stop",       1,0,1,0, 0,1, 0,1, 5'd2, 0,0));
    tbl.push_back(mk("ab_d1",         1,1,1,0, 0,0, 0,1, 5'd2, 0,0));
    tbl.push_back(mk("ab_d2",         1,1,1,0, 0,0, 0,1, 5'd2, 0,0));
    tbl.push_back(mk("ab_release",    0,1,1,0, 0,0, 0,1, 5'd2, 0,0));
    tbl.push_back(mk("ab_resume",     0,1,1,0, 1,1, 0,1, 5'd3, 0,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk($sformatf("ab_down%0d", i), 0,0,1,1, 0,1, 0,1, 5'(2 - i), 0,0));
    // Timeout: flag set after the 8th DRAIN cycle, late response still stops.
    tbl.push_back(mk("to_issue",      0,1,1,0, 1,1, 0,1, 5'd1, 0,0));
    tbl.push_back(mk("to_stop",       1,0,1,0, 0,1, 0,1, 5'd1, 0,0));
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk($sformatf("to_drain%0d", k), 1,1,1,0, 0,0, 0,1, 5'd1, 0,(k >= 7)));
    tbl.push_back(mk("to_late_rsp",   1,0,1,1, 0,0, 1,0, 5'd0, 0,1));
    tbl.push_back(mk("to_stopped",    1,0,1,0, 0,0, 1,0, 5'd0, 0,1));

    repeat (2) @(posedge sys_clk);
    #1;
    check("reset/stop_ack",      stop_ack,      1'b0);
    check("reset/task_clk_en",   task_clk_en,   1'b1);
    check("reset/outstanding",   outstanding,   5'd0);
    check("reset/protocol_err",  protocol_err,  1'b0);
    check("reset/drain_timeout", drain_timeout, 1'b0);
    @(negedge sys_clk);
    sys_reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Reset while STOPPED returns every output to its reset value.
    reset_and_check("rst_stopped");

    // Response with nothing outstanding: count holds at 0, sticky error.
    apply(mk("uf_rsp",     0,0,1,1, 0,1, 0,1, 5'd0, 1,0));
    apply(mk("uf_sticky",  0,0,1,0, 0,1, 0,1, 5'd0, 1,0));

    // Reset mid-DRAIN drops the in-flight count; its late response is an error.
    apply(mk("rd_issue",   0,1,1,0, 1,1, 0,1, 5'd1, 1,0));
    apply(mk("rd_stop",    1,0,1,0, 0,1, 0,1, 5'd1, 1,0));
    reset_and_check("rst_drain");
    apply(mk("rd_late",    0,0,1,1, 0,1, 0,1, 5'd0, 1,0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
